// File: rtl/fa_bist_checker.sv
// On-chip stimulus/response checker for a full-adder cell: sweeps all eight
// {a,b,c} vectors, checks s/co, reports a saturating error count and a verdict.
// Optional first-failure log ports are enabled by defining FA_BIST_LOG_EN.
module fa_bist_checker #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERRW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            fa_a,
  output logic            fa_b,
  output logic            fa_c,
  input  logic            fa_s,
  input  logic            fa_co,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt
`ifdef FA_BIST_LOG_EN
  ,
  output logic            fail_vld,
  output logic [2:0]      fail_vec,
  output logic [1:0]      fail_got
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  logic [1:0]      state;
  logic [2:0]      vec;
  logic [SW-1:0]   settle_cnt;
  logic [PW-1:0]   pass_idx;
  logic            s_exp, co_exp, mism;
  logic [ERRW-1:0] err_nxt;

  // vec is cleared on entry to DONE, so it doubles as the registered stimulus
  assign fa_a = vec[2];
  assign fa_b = vec[1];
  assign fa_c = vec[0];

  assign s_exp  = vec[2] ^ vec[1] ^ vec[0];
  assign co_exp = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mism   = (fa_s != s_exp) || (fa_co != co_exp);

  always_comb begin
    err_nxt = err_cnt;
    if (mism && (err_cnt != {ERRW{1'b1}}))
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 3'd0;
      settle_cnt <= '0;
      pass_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            vec        <= 3'd0;
            settle_cnt <= SW'(SETTLE - 1);
            pass_idx   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
          end
        end
        APPLY: begin
          if (settle_cnt == '0)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          err_cnt    <= err_nxt;
          settle_cnt <= SW'(SETTLE - 1);
          if (vec != 3'd7) begin
            vec   <= vec + 3'd1;
            state <= APPLY;
          end else if (pass_idx != PW'(PASSES - 1)) begin
            vec      <= 3'd0;
            pass_idx <= pass_idx + 1'b1;
            state    <= APPLY;
          end else begin
            vec   <= 3'd0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FA_BIST_LOG_EN
  // only the first mismatch of a run is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vld <= 1'b0;
      fail_vec <= 3'd0;
      fail_got <= 2'd0;
    end else if ((state == IDLE || state == DONE) && start) begin
      fail_vld <= 1'b0;
      fail_vec <= 3'd0;
      fail_got <= 2'd0;
    end else if (state == CHECK && mism && !fail_vld) begin
      fail_vld <= 1'b1;
      fail_vec <= vec;
      fail_got <= {fa_s, fa_co};
    end
  end
`endif

endmodule
